// File: rtl/mem_dram_ctrl.sv
// MEM-stage DRAM access sequencer: turns one pipeline memory request into registered
// DRAM read/write cycles. Sub-word stores go through read-modify-write via the aligner.
module mem_dram_ctrl #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic [1:0]        mem_we,
    input  logic              mem_re,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [31:0]       merged_wdata,
    input  logic [31:0]       dram_rdata,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_we,
    output logic [31:0]       dram_wdata,
    output logic [31:0]       rdata_q,
    output logic              load_valid,
    output logic              misalign,
    output logic              stall
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] WR      = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;
    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);

    logic [1:0] state;
    logic [1:0] rd_cnt;
    logic       is_load;
    logic       wr_ph;
    logic       accept_able;
    logic       misaligned;
    logic       word_store;

    // Request decode; a store size other than none always wins over mem_re.
    always_comb begin
        accept_able = (mem_we != 2'b00) || mem_re;
        misaligned  = ((mem_we == 2'b11) && (mem_addr[1:0] != 2'b00)) ||
                      ((mem_we == 2'b10) && mem_addr[0]);
        word_store  = (mem_we == 2'b11) && (mem_addr[1:0] == 2'b00);
    end

    // Hold the pipeline while a request is being accepted or is in flight.
    always_comb begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            stall = ((state == IDLE) && mem_req && accept_able) ||
                    (state == RD_WAIT) || (state == WR);
        end
    end

    // Access sequencer; wr_ph=1 means dram_wdata is valid and dram_we is being issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_cnt     <= 2'd0;
            is_load    <= 1'b0;
            wr_ph      <= 1'b0;
            dram_addr  <= '0;
            dram_we    <= 1'b0;
            dram_wdata <= 32'd0;
            rdata_q    <= 32'd0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            dram_we    <= 1'b0;
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req && accept_able) begin
                        dram_addr <= mem_addr[ADDR_W+1:2];
                        rd_cnt    <= 2'd0;
                        if (misaligned) begin
                            misalign <= 1'b1;
                            state    <= RESP;
                        end else if (word_store) begin
                            dram_wdata <= mem_wdata;
                            dram_we    <= 1'b1;
                            wr_ph      <= 1'b1;
                            state      <= WR;
                        end else begin
                            is_load <= (mem_we == 2'b00);
                            state   <= RD_WAIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt == RD_LAST) begin
                        rdata_q <= dram_rdata;
                        rd_cnt  <= 2'd0;
                        if (is_load) begin
                            load_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            wr_ph <= 1'b0;
                            state <= WR;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                WR: begin
                    // First RMW write cycle: the aligner has just seen the new rdata_q.
                    if (!wr_ph) begin
                        dram_wdata <= merged_wdata;
                        dram_we    <= 1'b1;
                        wr_ph      <= 1'b1;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dram_ctrl.sv
// Directed bench for mem_dram_ctrl: instance a uses RD_LAT=1, instance b uses RD_LAT=3,
// sharing one DRAM array and an aligner model; sel picks the instance under test.
module tb_mem_dram_ctrl;

    logic        clk = 1'b0;
    logic        rst, req, re, sel;
    logic [1:0]  we;
    logic [31:0] addr, wdata, merged;

    logic [13:0] a_dram_addr, b_dram_addr, s_dram_addr;
    logic        a_we, b_we, s_we, a_lv, b_lv, s_lv, a_ma, b_ma, s_ma, a_stall, b_stall, s_stall;
    logic [31:0] a_wdata, b_wdata, s_wdata, a_rq, b_rq, s_rq, a_rdata, b_rdata;
    logic [31:0] pb1, pb2;
    logic [31:0] dmem [0:63];

    int total = 0;
    int passed = 0;
    int wr_cnt = 0;
    int wr0, stalls;
    logic lv, ma;

    always #5 clk = ~clk;

    mem_dram_ctrl #(.ADDR_W(14), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .mem_req(req && !sel), .mem_we(we), .mem_re(re),
        .mem_addr(addr), .mem_wdata(wdata), .merged_wdata(merged), .dram_rdata(a_rdata),
        .dram_addr(a_dram_addr), .dram_we(a_we), .dram_wdata(a_wdata), .rdata_q(a_rq),
        .load_valid(a_lv), .misalign(a_ma), .stall(a_stall));

    mem_dram_ctrl #(.ADDR_W(14), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .mem_req(req && sel), .mem_we(we), .mem_re(re),
        .mem_addr(addr), .mem_wdata(wdata), .merged_wdata(merged), .dram_rdata(b_rdata),
        .dram_addr(b_dram_addr), .dram_we(b_we), .dram_wdata(b_wdata), .rdata_q(b_rq),
        .load_valid(b_lv), .misalign(b_ma), .stall(b_stall));

    assign a_rdata     = dmem[a_dram_addr[5:0]];
    assign b_rdata     = pb2;
    assign s_dram_addr = sel ? b_dram_addr : a_dram_addr;
    assign s_we        = sel ? b_we : a_we;
    assign s_wdata     = sel ? b_wdata : a_wdata;
    assign s_rq        = sel ? b_rq : a_rq;
    assign s_lv        = sel ? b_lv : a_lv;
    assign s_ma        = sel ? b_ma : a_ma;
    assign s_stall     = sel ? b_stall : a_stall;

    // DRAM model: latency-3 read pipe for instance b, single write port.
    always @(posedge clk) begin
        pb1 <= dmem[b_dram_addr[5:0]];
        pb2 <= pb1;
        if (s_we) begin
            dmem[s_dram_addr[5:0]] <= s_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Aligner model: merge store data into the captured word.
    always_comb begin
        merged = s_rq;
        if (we == 2'b01) begin
            merged[8*addr[1:0] +: 8] = wdata[7:0];
        end else if (we == 2'b10) begin
            merged[16*addr[1] +: 16] = wdata[15:0];
        end else begin
            merged = s_rq;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op_we, input logic op_re, input logic [31:0] op_addr,
                          input logic [31:0] op_wdata, output int n_stall,
                          output logic o_lv, output logic o_ma);
        bit done;
        @(negedge clk);
        we = op_we; re = op_re; addr = op_addr; wdata = op_wdata; req = 1'b1;
        #1;
        n_stall = 0;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            if (s_stall) begin
                n_stall++;
                @(negedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        o_lv = s_lv;
        o_ma = s_ma;
        if (!done) check_eq("op_timeout", 32'd0, 32'd1);
        req = 1'b0; we = 2'b00; re = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
        dmem[4] = 32'h11223344;
        dmem[8] = 32'h99999999;
        sel = 1'b0; rst = 1'b1; req = 1'b1; we = 2'b11; re = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("stall_in_reset", 32'(a_stall), 32'd0);
        check_eq("reset_dram_we", 32'(a_we), 32'd0);
        check_eq("reset_dram_addr", 32'(a_dram_addr), 32'd0);
        check_eq("reset_rdata_q", a_rq, 32'd0);
        check_eq("reset_pulses", {30'd0, a_lv, a_ma}, 32'd0);
        req = 1'b0; we = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 1'b0, 32'h10, 32'h0, stalls, lv, ma);
        check_eq("noop_stall", stalls, 32'd0);

        wr0 = wr_cnt;
        run_op(2'b00, 1'b1, 32'h10, 32'h0, stalls, lv, ma);
        check_eq("load_stall", stalls, 32'd2);
        check_eq("load_valid", 32'(lv), 32'd1);
        check_eq("load_rdata_q", s_rq, 32'h11223344);
        check_eq("load_no_write", wr_cnt - wr0, 32'd0);

        wr0 = wr_cnt;
        run_op(2'b01, 1'b0, 32'h11, 32'h000000AB, stalls, lv, ma);
        check_eq("byte_st_stall", stalls, 32'd4);
        check_eq("byte_st_writes", wr_cnt - wr0, 32'd1);
        check_eq("byte_st_mem", dmem[4], 32'h1122AB44);
        check_eq("byte_st_wdata", s_wdata, 32'h1122AB44);
        check_eq("byte_st_pulses", {30'd0, lv, ma}, 32'd0);

        wr0 = wr_cnt;
        run_op(2'b11, 1'b1, 32'h20, 32'hDEADBEEF, stalls, lv, ma);
        check_eq("word_st_stall", stalls, 32'd2);
        check_eq("word_st_writes", wr_cnt - wr0, 32'd1);
        check_eq("word_st_addr", 32'(s_dram_addr), 32'd8);
        check_eq("word_st_mem", dmem[8], 32'hDEADBEEF);
        check_eq("rdata_q_hold", s_rq, 32'h11223344);

        wr0 = wr_cnt;
        run_op(2'b10, 1'b0, 32'h13, 32'h00001234, stalls, lv, ma);
        check_eq("misal_stall", stalls, 32'd1);
        check_eq("misal_pulse", {30'd0, lv, ma}, 32'd1);
        check_eq("misal_no_write", wr_cnt - wr0, 32'd0);
        check_eq("misal_mem", dmem[4], 32'h1122AB44);

        run_op(2'b10, 1'b0, 32'h22, 32'h00005555, stalls, lv, ma);
        check_eq("half_st_stall", stalls, 32'd4);
        check_eq("half_st_mem", dmem[8], 32'h5555BEEF);

        // Reset in the first WR cycle, before dram_we would be raised.
        wr0 = wr_cnt;
        @(negedge clk);
        we = 2'b01; re = 1'b0; addr = 32'h21; wdata = 32'h00000077; req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_stall", 32'(s_stall), 32'd0);
        @(negedge clk);
        #1;
        check_eq("rst_mid_we", 32'(s_we), 32'd0);
        check_eq("rst_mid_wdata", s_wdata, 32'd0);
        check_eq("rst_mid_addr", 32'(s_dram_addr), 32'd0);
        req = 1'b0; we = 2'b00; rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_no_write", wr_cnt - wr0, 32'd0);
        check_eq("rst_mid_mem", dmem[8], 32'h5555BEEF);
        run_op(2'b11, 1'b0, 32'h0, 32'h0BADF00D, stalls, lv, ma);
        check_eq("post_rst_stall", stalls, 32'd2);
        check_eq("post_rst_mem", dmem[0], 32'h0BADF00D);

        // RD_LAT=3 instance: load then word store back-to-back.
        sel = 1'b1;
        run_op(2'b00, 1'b1, 32'h10, 32'h0, stalls, lv, ma);
        check_eq("lat3_load_stall", stalls, 32'd4);
        check_eq("lat3_load_valid", 32'(lv), 32'd1);
        check_eq("lat3_rdata_q", s_rq, 32'h1122AB44);
        wr0 = wr_cnt;
        run_op(2'b11, 1'b0, 32'h30, 32'hCAFEF00D, stalls, lv, ma);
        check_eq("b2b_st_stall", stalls, 32'd2);
        check_eq("b2b_st_writes", wr_cnt - wr0, 32'd1);
        check_eq("b2b_st_addr", 32'(s_dram_addr), 32'd12);
        check_eq("b2b_st_mem", dmem[12], 32'hCAFEF00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
